// File: rtl/wb_arb_pkg.sv
// Shared types for the two-port Wishbone arbiter: FSM states, port indices
// and the request record that is captured, replayed and held while granted.
package wb_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data_wr;
    logic [1:0]  width_hint;
  } wb_req_t;

endpackage

// File: rtl/wb_req_capture.sv
// One-entry holding buffer for a single-cycle strobe that could not be
// forwarded at once; dropped if the requester abandons the cycle.
module wb_req_capture
  import wb_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    capture,
  input  logic    consume,
  input  logic    cyc_drop,
  input  wb_req_t req_in,
  output logic    valid,
  output wb_req_t req
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else begin
      if (consume || cyc_drop) valid <= 1'b0;
      else if (capture)        valid <= 1'b1;
      if (capture) req <= req_in;
    end
  end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Round-robin 2:1 Wishbone arbiter (port 0 ifetch, port 1 data) with strobe
// capture/replay and a bus timeout that turns a hung transfer into err.
module wb_arbiter_2to1
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // requester 0 (instruction fetch)
  input  logic        wb_p0_cyc,
  input  logic        wb_p0_stb,
  input  logic        wb_p0_we,
  input  logic [3:0]  wb_p0_sel,
  input  logic [31:0] wb_p0_addr,
  input  logic [31:0] wb_p0_data_wr,
  output logic [31:0] wb_p0_data_rd,
  output logic        wb_p0_ack,
  output logic        wb_p0_err,
  // requester 1 (data membus)
  input  logic        wb_p1_cyc,
  input  logic        wb_p1_stb,
  input  logic        wb_p1_we,
  input  logic [3:0]  wb_p1_sel,
  input  logic [31:0] wb_p1_addr,
  input  logic [31:0] wb_p1_data_wr,
  output logic [31:0] wb_p1_data_rd,
  output logic        wb_p1_ack,
  output logic        wb_p1_err,
  input  logic [1:0]  i_width_hint0,
  input  logic [1:0]  i_width_hint1,
  // shared downstream bus
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data_wr,
  input  logic [31:0] wb_data_rd,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic [1:0]  o_bus_width_hint,
  output logic        o_grant,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam int            CW       = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

  arb_state_t     state, state_nxt;
  logic           last_grant;
  logic [CW-1:0]  cnt;
  wb_req_t        grant_req, fwd_req, out_req;
  wb_req_t [1:0]  live_req, pend_req;
  logic [1:0]     cyc_in, live, fresh, cand, cap, consume, pend_valid, ack, err;
  logic [1:0][31:0] data_rd;
  logic           win, issue, owner_cyc, owner_done;

  assign cyc_in = {wb_p1_cyc, wb_p0_cyc};
  assign live   = cyc_in & {wb_p1_stb, wb_p0_stb};
  // a strobe from a port that already has a pending entry is illegal and ignored
  assign fresh  = live & ~pend_valid;
  assign cand   = fresh | (pend_valid & cyc_in);

  assign live_req[0] = '{addr: wb_p0_addr, we: wb_p0_we, sel: wb_p0_sel,
                         data_wr: wb_p0_data_wr, width_hint: i_width_hint0};
  assign live_req[1] = '{addr: wb_p1_addr, we: wb_p1_we, sel: wb_p1_sel,
                         data_wr: wb_p1_data_wr, width_hint: i_width_hint1};

  assign win       = (&cand) ? ~last_grant : cand[PORT_DMEM];
  assign fwd_req   = fresh[win] ? live_req[win] : pend_req[win];
  assign owner_cyc = cyc_in[last_grant];

  for (genvar n = 0; n < 2; n++) begin : g_port
    assign consume[n] = issue && (win == 1'(n));
    // the owner may only re-strobe in the cycle it receives its ack/err
    assign cap[n] = fresh[n] && !consume[n] &&
                    !(state == BUSY && last_grant == 1'(n) && !owner_done);
    wb_req_capture u_cap (
      .clk      (i_clk),
      .rst      (i_rst),
      .capture  (cap[n]),
      .consume  (consume[n]),
      .cyc_drop (!cyc_in[n]),
      .req_in   (live_req[n]),
      .valid    (pend_valid[n]),
      .req      (pend_req[n])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    owner_done = 1'b0;
    out_req    = grant_req;
    wb_cyc     = 1'b0;
    wb_stb     = 1'b0;
    ack        = '0;
    err        = '0;
    data_rd    = '0;
    o_timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          issue     = 1'b1;
          wb_cyc    = 1'b1;
          wb_stb    = 1'b1;
          out_req   = fwd_req;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_nxt = IDLE;
        end else begin
          wb_cyc              = 1'b1;
          data_rd[last_grant] = wb_data_rd;
          if (wb_ack || wb_err) begin
            ack[last_grant] = wb_ack;
            err[last_grant] = wb_err;
            owner_done      = 1'b1;
            state_nxt       = IDLE;
          end else if (TMO_EN && cnt == TMO_LAST) begin
            wb_cyc          = 1'b0;
            err[last_grant] = 1'b1;
            o_timeout       = 1'b1;
            owner_done      = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (i_rst) begin
      issue     = 1'b0;
      wb_cyc    = 1'b0;
      wb_stb    = 1'b0;
      ack       = '0;
      err       = '0;
      o_timeout = 1'b0;
    end
  end

  // last_grant doubles as the current owner index reported on o_grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= PORT_IMEM;
      cnt        <= '0;
      grant_req  <= '0;
    end else if (issue) begin
      last_grant <= win;
      cnt        <= '0;
      grant_req  <= fwd_req;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign wb_we            = out_req.we;
  assign wb_sel           = out_req.sel;
  assign wb_addr          = out_req.addr;
  assign wb_data_wr       = out_req.data_wr;
  assign o_bus_width_hint = out_req.width_hint;
  assign o_busy           = (state == BUSY) && !i_rst;
  assign o_grant          = last_grant && !i_rst;

  assign wb_p0_ack     = ack[0];
  assign wb_p0_err     = err[0];
  assign wb_p0_data_rd = data_rd[0];
  assign wb_p1_ack     = ack[1];
  assign wb_p1_err     = err[1];
  assign wb_p1_data_rd = data_rd[1];

endmodule

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Shares one Wishbone controller port between two requesters: port 0 is instruction fetch, port 1 is the data membus.
- Requesters follow the single-cycle-strobe protocol: stb high for one cycle, cyc held until ack/err. The arbiter therefore captures any strobe it cannot forward immediately and replays it later.
- Arbitration is round-robin, with a bus timeout that converts a hung transaction into err.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUSY without ack/err before forced err; 0 disables the timeout.

Ports:
- i_clk  input  1  clock; one clock domain.
- i_rst  input  1  reset, synchronous, active-high.
- wb_p0  Wishbone.Peripheral  -  requester 0 (instruction fetch).
- wb_p1  Wishbone.Peripheral  -  requester 1 (data membus).
- i_width_hint0  input  2  bus width hint from requester 0.
- i_width_hint1  input  2  bus width hint from requester 1.
- wb  Wishbone.Controller  -  shared downstream bus.
- o_bus_width_hint  output  2  width hint of the forwarded/granted request.
- o_grant  output  1  index of the current owner; valid while o_busy.
- o_busy  output  1  high in BUSY state.
- o_timeout  output  1  one-cycle pulse when a timeout err is issued.

Behaviour:
- States: IDLE, BUSY. Reset: IDLE, pend0=pend1=0, last_grant=0, timeout counter=0.
- Reset outputs: wb.cyc=wb.stb=0, both requester ack/err=0, o_busy=0, o_timeout=0, o_grant=0.
- Live request on port n: wb_pn.cyc && wb_pn.stb.
- Capture buffer: a live request that is not forwarded in the same cycle is latched into pend_n. Latched fields: addr, we, sel, data_wr, width hint.
- Stale pending: pend_n clears if wb_pn.cyc deasserts while pending.
- Illegal stb: a second stb from a port whose pend_n=1 or that is granted and awaiting ack. The bench flags it under VERIFICATION and the RTL ignores it.
- Candidates in IDLE: port n is a candidate if it is live or pend_n=1.
  - One candidate: that port wins.
  - Two candidates: the port != last_grant wins. After reset, port 1 wins the first tie.
- Forwarding: the winner is driven to wb in the same IDLE cycle.
  - Source is the live inputs if live, else pend_n.
  - wb.stb=wb.cyc=1 for that one cycle; the winning pend_n clears.
  - Zero added latency for a live win; a pending win is issued the cycle it is chosen.
  - Next state BUSY; last_grant and o_grant take the winner.
- BUSY:
  - wb.stb=0; wb.cyc=1; addr/we/sel/data_wr/width hint held from a grant register.
  - wb.ack, wb.err and wb.data_rd route combinationally to the owner only; the other port sees ack=err=0.
  - On wb.ack or wb.err: go to IDLE next cycle. No new grant is issued in the ack cycle.
  - Any stb arriving during BUSY, including from the owner in its own ack cycle, is captured into pend.
  - Back-to-back transactions therefore cost one IDLE cycle.
- Owner abort: owner drops cyc during BUSY → wb.cyc=0 that cycle, return to IDLE. A late ack/err is ignored and not routed.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1); cleared on grant; increments each BUSY cycle.
  - At TIMEOUT_CYCLES with no ack/err: owner err=1 for one cycle, wb.cyc=0, o_timeout=1, go to IDLE.
  - Ack/err in the same cycle as expiry → ack/err wins; no o_timeout.
- Reset mid-transaction: drops wb.cyc the same cycle (outputs gated by i_rst) and clears pend and state.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum arb_state_t {IDLE, BUSY};
  - localparams PORT_IMEM=0, PORT_DMEM=1;
  - packed struct wb_req_t {addr[31:0], we, sel[3:0], data_wr[31:0], width_hint[1:0]}.
- Sub-module wb_req_capture, instantiated once per port:
  - one-entry wb_req_t buffer with valid flag;
  - inputs: capture, consume, cyc_drop;
  - outputs: valid and the stored request.

Test Plan:
- Single dmem read of addr 0x100, peripheral acks after 3 cycles with 0xDEADBEEF:
  - wb.stb same cycle as wb_p1.stb; wb.cyc high for 4 cycles;
  - wb_p1 sees ack and data 0xDEADBEEF; wb_p0.ack stays 0.
- After reset, both ports strobe in the same cycle (p0 addr 0x0, p1 addr 0x200):
  - p1 forwarded first; p0 captured;
  - one IDLE cycle after p1's ack, p0 is issued with addr 0x0 and unchanged sel/data.
- Round-robin: both ports strobe continuously (each re-strobes in its ack cycle) for 8 transactions → grants alternate 1,0,1,0…
- Owner strobes in its own ack cycle: captured to pend and issued after one IDLE cycle with the correct data_wr 0x12345678 and sel 4'b1100.
- TIMEOUT_CYCLES=4, peripheral never acks:
  - err to owner and o_timeout high in exactly the 5th BUSY cycle, wb.cyc low that cycle;
  - next request still served.
- i_rst asserted during BUSY with p0 pending:
  - wb.cyc=0 that cycle, pend cleared, no ack/err delivered;
  - first tie after reset goes to p1.
